// File: rtl/muldiv_seq.sv
// Iterative RV32M/RV64M multiply/divide unit, one bit per cycle, valid/ready on both sides.
// Optional single-cycle trivial-operand path enabled by defining MULDIV_FASTPATH_EN.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  acc_q, acc_d;     // mul: high product half; div: partial remainder
  logic [XLEN-1:0]  lo_q, lo_d;       // mul: multiplier/low half; div: dividend/quotient
  logic [XLEN-1:0]  opb_q, opb_d;     // mul: multiplicand; div: divisor
  logic [2:0]       f3_q, f3_d;
  logic             neg_q, neg_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             out_valid_q, out_valid_d;

  logic             a_sgn, b_sgn, is_div, accept;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN:0]    mul_sum, div_shift;
  logic [XLEN+1:0]  div_diff;
  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0]  div_sel, div_f, fix_res;
  logic             fast_hit;
  logic [XLEN-1:0]  fast_res;

  // Operand conditioning and datapath step/fix values.
  always_comb begin
    is_div   = func3[2];
    a_sgn    = ((func3 == 3'd1) || (func3 == 3'd2) || (func3 == 3'd4) || (func3 == 3'd6)) && rs1[XLEN-1];
    b_sgn    = ((func3 == 3'd1) || (func3 == 3'd4) || (func3 == 3'd6)) && rs2[XLEN-1];
    a_mag    = a_sgn ? (~rs1 + {{(XLEN-1){1'b0}}, 1'b1}) : rs1;
    b_mag    = b_sgn ? (~rs2 + {{(XLEN-1){1'b0}}, 1'b1}) : rs2;
    accept   = in_valid && (state_q == S_IDLE) && !flush;

    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};

    prod    = {acc_q, lo_q};
    prod_f  = neg_q ? (~prod + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod;
    div_sel = f3_q[1] ? acc_q : lo_q;
    div_f   = neg_q ? (~div_sel + {{(XLEN-1){1'b0}}, 1'b1}) : div_sel;
    if (f3_q[2]) begin
      fix_res = div_f;
    end else if (f3_q[1:0] == 2'd0) begin
      fix_res = prod_f[XLEN-1:0];
    end else begin
      fix_res = prod_f[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_FASTPATH_EN
  // Trivial operand combinations resolved without iterating.
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (is_div) begin
      if (rs2 == '0) begin
        fast_hit = 1'b1;
        fast_res = func3[1] ? rs1 : {XLEN{1'b1}};
      end else if (!func3[0] && (rs1 == XMIN) && (rs2 == {XLEN{1'b1}})) begin
        fast_hit = 1'b1;
        fast_res = func3[1] ? {XLEN{1'b0}} : XMIN;
      end else if (func3[0] && (rs2 == {{(XLEN-1){1'b0}}, 1'b1})) begin
        fast_hit = 1'b1;
        fast_res = func3[1] ? {XLEN{1'b0}} : rs1;
      end else begin
        fast_hit = 1'b0;
      end
    end else begin
      if ((rs1 == '0) || (rs2 == '0)) begin
        fast_hit = 1'b1;
        fast_res = '0;
      end else if ((rs2 == {{(XLEN-1){1'b0}}, 1'b1}) && ((func3 == 3'd0) || (func3 == 3'd3))) begin
        fast_hit = 1'b1;
        fast_res = (func3 == 3'd0) ? rs1 : {XLEN{1'b0}};
      end else begin
        fast_hit = 1'b0;
      end
    end
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    opb_d       = opb_q;
    f3_d        = f3_q;
    neg_d       = neg_q;
    tag_d       = tag_q;
    result_d    = result_q;
    out_valid_d = (state_q == S_DONE) && !(out_valid_q && out_ready);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d  = func3;
          tag_d = in_tag;
          cnt_d = '0;
          acc_d = '0;
          lo_d  = is_div ? a_mag : b_mag;
          opb_d = is_div ? b_mag : a_mag;
          if (is_div && func3[1]) begin
            neg_d = a_sgn;
          end else if (is_div) begin
            neg_d = (a_sgn ^ b_sgn) && (rs2 != '0);  // x/0 gives all-ones regardless of sign
          end else begin
            neg_d = a_sgn ^ b_sgn;
          end
          if (fast_hit) begin
            result_d = fast_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (f3_q[2]) begin
          acc_d = div_diff[XLEN+1] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], ~div_diff[XLEN+1]};
        end else begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      out_valid_d = out_valid_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      f3_q        <= 3'd0;
      neg_q       <= 1'b0;
      tag_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      opb_q       <= opb_d;
      f3_q        <= f3_d;
      neg_q       <= neg_d;
      tag_q       <= tag_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq at XLEN=32 with hand-computed results.
module tb_muldiv_seq;
  localparam int XLEN = 32;
  localparam int FULL_LAT = XLEN + 2;
`ifdef MULDIV_FASTPATH_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = FULL_LAT;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  out_tag;

  int n_checks = 0;
  int n_fail = 0;

  muldiv_seq #(.XLEN(XLEN), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .func3(func3), .rs1(rs1), .rs2(rs2), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure latency, optionally stall the consumer, then complete the handshake.
  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tg, input logic [31:0] exp,
                       input int lat, input int hold);
    int edges;
    logic [31:0] held;
    logic stable;
    edges = 0;
    while (!in_ready && edges < 10) begin
      @(posedge clk); #1; edges++;
    end
    check({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    func3 = f; rs1 = a; rs2 = b; in_tag = tg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1; edges++;
    end
    check({name, "_latency"}, 64'(edges), 64'(lat));
    check({name, "_result"}, {32'd0, result}, {32'd0, exp});
    check({name, "_tag"}, {59'd0, out_tag}, {59'd0, tg});
    if (hold > 0) begin
      held = result;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      end
      check({name, "_stall_stable"}, {63'd0, stable}, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    logic seen;
    #12;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    check("reset_out_tag", {59'd0, out_tag}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("mul_7_m3",   3'd0, 32'd7,          32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, FULL_LAT, 0);
    do_op("mulh_min",   3'd1, 32'h80000000,   32'h80000000, 5'd1,  32'h40000000, FULL_LAT, 0);
    do_op("mulhsu",     3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF, FULL_LAT, 0);
    do_op("mulhu",      3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, FULL_LAT, 0);
    do_op("div_m7_2",   3'd4, 32'hFFFFFFF9,   32'd2,        5'd4,  32'hFFFFFFFD, FULL_LAT, 0);
    do_op("rem_m7_2",   3'd6, 32'hFFFFFFF9,   32'd2,        5'd5,  32'hFFFFFFFF, FULL_LAT, 0);
    do_op("divu_100_7", 3'd5, 32'd100,        32'd7,        5'd6,  32'd14,       FULL_LAT, 0);
    do_op("remu_100_7", 3'd7, 32'd100,        32'd7,        5'd7,  32'd2,        FULL_LAT, 0);
    do_op("div_x_0",    3'd4, 32'h12345678,   32'd0,        5'd8,  32'hFFFFFFFF, FAST_LAT, 0);
    do_op("div_neg_0",  3'd4, 32'hFFFFFFFB,   32'd0,        5'd10, 32'hFFFFFFFF, FAST_LAT, 0);
    do_op("rem_x_0",    3'd6, 32'h12345678,   32'd0,        5'd11, 32'h12345678, FAST_LAT, 0);
    do_op("div_ovf",    3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd12, 32'h80000000, FAST_LAT, 0);
    do_op("rem_ovf",    3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd13, 32'd0,        FAST_LAT, 0);
    do_op("divu_x_1",   3'd5, 32'hDEADBEEF,   32'd1,        5'd14, 32'hDEADBEEF, FAST_LAT, 0);
    do_op("mulhu_x_1",  3'd3, 32'hDEADBEEF,   32'd1,        5'd15, 32'd0,        FAST_LAT, 0);
    do_op("mul_signed", 3'd0, 32'hFFFFFF00,   32'h00000100, 5'd16, 32'hFFFF0000, FULL_LAT, 0);
    do_op("rem_m100_7", 3'd6, 32'hFFFFFF9C,   32'hFFFFFFF9, 5'd17, 32'hFFFFFFFE, FULL_LAT, 0);
    // Consumer stall, then back-to-back request right after the handshake.
    do_op("stall_mul",  3'd0, 32'd12,         32'd11,       5'd18, 32'd132,      FULL_LAT, 10);
    check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
    do_op("b2b_divu",   3'd5, 32'd1000,       32'd10,       5'd19, 32'd100,      FULL_LAT, 0);

    // Flush during CALC.
    func3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; in_tag = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flush_busy", {63'd0, in_ready}, 64'd0);
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", {63'd0, seen}, 64'd0);

    // Request presented together with flush is dropped.
    func3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_req_dropped", {63'd0, in_ready}, 64'd1);

    // Asynchronous reset in the middle of CALC.
    do_op("pre_reset",  3'd0, 32'd5,          32'd6,        5'd21, 32'd30,       FULL_LAT, 0);
    func3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; in_tag = 5'd22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_result", {32'd0, result}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_out_tag", {59'd0, out_tag}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_op("post_reset", 3'd7, 32'd17,         32'd5,        5'd23, 32'd2,        FULL_LAT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
